mult_ctrl: RTL and testbench

//  Sequencer for the shiftadder radix-2 Booth multiply datapath in multdiv.
//  - Accepts a one-cycle ctrl_MULT request and latches both operands.
//  - Clears the shiftadder accumulator, then steps its counter through 0..31.
//  - Derives the exception flag and presents result + one-cycle ready to the pipeline.

---
 rtl/mult_ctrl_pkg.sv | 25 ++
 rtl/mult_ctrl_if.sv | 33 +++
 rtl/mult_ctrl_counter5.sv | 25 ++
 rtl/mult_ctrl.sv | 86 ++++++++
 tb/tb_mult_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the Booth multiply sequencer.
// The exception helper compares the product sign against the sign of the operands.
package mult_ctrl_pkg;

  localparam int WIDTH = 32;
  localparam int CT_W  = 5;
  localparam logic [CT_W-1:0] CT_LAST = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  // A product of two non-zero operands must carry the XOR of their signs.
  // A zero operand masks the check.
  function automatic logic sign_err(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] res);
    return (a != '0) && (b != '0) && (res[WIDTH-1] != (a[WIDTH-1] ^ b[WIDTH-1]));
  endfunction

endpackage

// File: rtl/mult_ctrl_if.sv
// Pipeline-side request/result and shiftadder-side control signals of the multiply sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline and shiftadder.
interface mult_ctrl_if;
  import mult_ctrl_pkg::*;

  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  logic [WIDTH-1:0] sa_A;
  logic [WIDTH-1:0] sa_B;
  logic [CT_W-1:0]  sa_ct;
  logic             sa_rst;
  logic [WIDTH-1:0] sa_result;
  logic             sa_ovf;

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB, sa_result, sa_ovf,
    output data_result, data_exception, data_resultRDY, busy,
           sa_A, sa_B, sa_ct, sa_rst
  );

  modport master (
    output ctrl_MULT, data_operandA, data_operandB, sa_result, sa_ovf,
    input  data_result, data_exception, data_resultRDY, busy,
           sa_A, sa_B, sa_ct, sa_rst
  );

endinterface

// File: rtl/mult_ctrl_counter5.sv
// Booth step counter: up-counter with synchronous clear and enable.
// It wraps naturally from 31 back to 0.
module mult_ctrl_counter5
  import mult_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic            clr,
  input  logic            en,
  output logic [CT_W-1:0] ct
);

  localparam logic [CT_W-1:0] CT_ONE = 1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ct <= '0;
    end else if (clr) begin
      ct <= '0;
    end else if (en) begin
      ct <= ct + CT_ONE;
    end
  end

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for the radix-2 Booth shiftadder: latches the operands, clears the accumulator,
// steps ct through 0..31, then presents the product with a one-cycle ready pulse.
//   state  | meaning
//   IDLE   | no operation yet, accumulator held in clear
//   LOAD   | one cycle: clear accumulator, step counter and sticky overflow
//   RUN    | one Booth step per edge, ct = 0..31
//   DONE   | one cycle: result final, ready pulse
//   HOLD   | Booth pair forced to 00 so the result stays put
module mult_ctrl
  import mult_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      nrst,
  mult_ctrl_if.slave bus
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] op_a, op_b;
  logic             sticky;
  logic [CT_W-1:0]  ct;
  logic             ct_clr, ct_en;

  mult_ctrl_counter5 u_ct (
    .clk  (clk),
    .nrst (nrst),
    .clr  (ct_clr),
    .en   (ct_en),
    .ct   (ct)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= S_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sticky <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.ctrl_MULT) begin
        op_a <= bus.data_operandA;
        op_b <= bus.data_operandB;
      end
      if (state == S_LOAD) begin
        sticky <= 1'b0;
      end else if (state == S_RUN) begin
        sticky <= sticky | bus.sa_ovf;
      end
    end
  end

  // A new request restarts from any state, including the edge that would enter DONE.
  always_comb begin
    state_nx = state;
    ct_clr   = 1'b0;
    ct_en    = 1'b0;
    case (state)
      S_IDLE: state_nx = S_IDLE;
      S_LOAD: begin
        ct_clr   = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        ct_en = 1'b1;
        if (ct == CT_LAST) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_HOLD;
      S_HOLD:  state_nx = S_HOLD;
      default: state_nx = S_IDLE;
    endcase
    if (bus.ctrl_MULT) state_nx = S_LOAD;
  end

  assign bus.sa_A           = op_a;
  assign bus.sa_B           = (state == S_RUN) ? op_b : '0;
  assign bus.sa_ct          = (state == S_RUN) ? ct : '0;
  assign bus.sa_rst         = (state == S_IDLE) || (state == S_LOAD);
  assign bus.busy           = (state == S_LOAD) || (state == S_RUN);
  assign bus.data_result    = bus.sa_result;
  assign bus.data_resultRDY = (state == S_DONE);

  // The accumulator holds the final sum from DONE onward and sticky only moves in RUN,
  // so evaluating the flag combinationally gives a stable value through HOLD.
  assign bus.data_exception = ((state == S_DONE) || (state == S_HOLD)) &&
                              (sticky || sign_err(op_a, op_b, bus.sa_result));

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl with a behavioural radix-2 Booth shiftadder attached.
// Expected products come from plain 64-bit signed multiplication.
module tb_mult_ctrl;

  logic clk = 1'b0;
  logic nrst;
  logic mask_ovf;
  int   checks = 0;
  int   errors = 0;
  int   rdy_total = 0;

  always #5 clk = ~clk;

  mult_ctrl_if bus ();

  mult_ctrl dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // Shiftadder: pair {B[ct], B[ct-1]} selects add/subtract of A<<ct; ovf flags a sum beyond 32 bits.
  logic [31:0]        acc;
  logic [1:0]         pair;
  logic signed [63:0] add64, nx64;

  always_comb begin
    pair  = {bus.sa_B[bus.sa_ct], (bus.sa_ct == 5'd0) ? 1'b0 : bus.sa_B[bus.sa_ct - 5'd1]};
    add64 = $signed({{32{bus.sa_A[31]}}, bus.sa_A}) <<< bus.sa_ct;
    nx64  = $signed({{32{acc[31]}}, acc});
    if (pair == 2'b01)      nx64 = nx64 + add64;
    else if (pair == 2'b10) nx64 = nx64 - add64;
  end

  assign bus.sa_result = acc;
  assign bus.sa_ovf    = !mask_ovf && (nx64 != $signed({{32{nx64[31]}}, nx64[31:0]}));

  always @(posedge clk) acc <= bus.sa_rst ? 32'd0 : nx64[31:0];

  always @(negedge clk) if (bus.data_resultRDY === 1'b1) rdy_total++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          mask;
    logic [31:0] res;
    bit          exc;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clk);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom();
    bus.data_operandB = $urandom();
  endtask

  // n counts edges from the request edge (inclusive) to the first cycle with ready high.
  task automatic wait_rdy(output int n);
    n = 1;
    while (bus.data_resultRDY !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit mask, input logic [31:0] er, input bit ee,
                           input bit chk_exc, input int hold_cycles);
    int n;
    int r0;
    int bad;
    mask_ovf = mask;
    r0 = rdy_total;
    start_op(a, b);
    wait_rdy(n);
    chk({tag, "_latency"}, 32'(n), 32'd34);
    chk({tag, "_result"}, bus.data_result, er);
    chk({tag, "_busy_on_rdy"}, {31'd0, bus.busy}, 32'd0);
    if (chk_exc) chk({tag, "_exception"}, {31'd0, bus.data_exception}, {31'd0, ee});
    bad = 0;
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.data_result !== er || bus.data_resultRDY !== 1'b0) bad++;
      if (chk_exc && bus.data_exception !== ee) bad++;
    end
    chk({tag, "_hold_stable"}, 32'(bad), 32'd0);
    chk({tag, "_rdy_count"}, 32'(rdy_total - r0), 32'd1);
    mask_ovf = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0]        ra, rb;
    logic signed [63:0] prod;
    int                 n, r0;

    vt[0] = '{32'd7,        32'd6,        1'b0, 32'd42,       1'b0};
    vt[1] = '{32'hFFFFFFFB, 32'd3,        1'b0, 32'hFFFFFFF1, 1'b0};
    vt[2] = '{32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 1'b1};
    vt[3] = '{32'd0,        32'h80000000, 1'b0, 32'h00000000, 1'b0};
    vt[4] = '{32'h40000000, 32'd2,        1'b1, 32'h80000000, 1'b1};
    vt[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b0};
    vt[6] = '{32'h80000000, 32'd1,        1'b1, 32'h80000000, 1'b0};

    nrst = 1'b0;
    mask_ovf = 1'b0;
    bus.ctrl_MULT = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",  {31'd0, bus.busy}, 32'd0);
    chk("reset_rdy",   {31'd0, bus.data_resultRDY}, 32'd0);
    chk("reset_exc",   {31'd0, bus.data_exception}, 32'd0);
    chk("reset_sarst", {31'd0, bus.sa_rst}, 32'd1);
    chk("reset_saB",   bus.sa_B, 32'd0);
    chk("reset_sact",  {27'd0, bus.sa_ct}, 32'd0);
    chk("reset_saA",   bus.sa_A, 32'd0);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++)
      run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].mask, vt[i].res, vt[i].exc, 1'b1, 20);

    // Small operands: no partial sum leaves 32 bits, so the exception is purely overflow of the product.
    for (int i = 0; i < 30; i++) begin
      ra = 32'($urandom_range(65535)) - 32'd32768;
      rb = 32'($urandom_range(65535)) - 32'd32768;
      prod = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
      run_check($sformatf("rnd%0d", i), ra, rb, 1'b0, prod[31:0],
                prod != $signed({{32{prod[31]}}, prod[31:0]}), 1'b1, 3);
    end
    for (int i = 0; i < 10; i++) begin
      ra = $urandom();
      rb = $urandom();
      prod = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
      run_check($sformatf("big%0d", i), ra, rb, 1'b0, prod[31:0], 1'b0, 1'b0, 3);
    end

    // Abort mid-run: the first operation must never signal ready.
    r0 = rdy_total;
    start_op(32'd3, 32'd4);
    repeat (11) @(posedge clk);
    #1;
    start_op(32'd9, 32'd9);
    wait_rdy(n);
    chk("abort_latency", 32'(n), 32'd34);
    chk("abort_result", bus.data_result, 32'd81);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_rdy_count", 32'(rdy_total - r0), 32'd1);

    // Restart on the final step edge: DONE is skipped.
    r0 = rdy_total;
    start_op(32'd5, 32'd5);
    repeat (32) @(posedge clk);
    #1;
    chk("restart_busy_before", {31'd0, bus.busy}, 32'd1);
    start_op(32'd11, 32'd3);
    wait_rdy(n);
    chk("restart_latency", 32'(n), 32'd34);
    chk("restart_result", bus.data_result, 32'd33);
    repeat (3) @(posedge clk);
    #1;
    chk("restart_rdy_count", 32'(rdy_total - r0), 32'd1);

    // Reset mid-run.
    r0 = rdy_total;
    start_op(32'd6, 32'd7);
    repeat (16) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    chk("midrst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("midrst_sarst", {31'd0, bus.sa_rst}, 32'd1);
    chk("midrst_saA",   bus.sa_A, 32'd0);
    @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_rdy", 32'(rdy_total - r0), 32'd0);
    chk("midrst_acc_clear", bus.data_result, 32'd0);
    run_check("after_rst", 32'd2, 32'd2, 1'b0, 32'd4, 1'b0, 1'b1, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
